// File: rtl/wash_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wash_sequencer
// Summary  : Parametrised washing-machine controller with one phase counter,
//            one remaining-time counter, pause/resume and door safety pause.
// Revision : 1.0 - initial release
// ============================================================================
module wash_sequencer #(
  parameter int TW      = 8,
  parameter int FILL_T  = 4,
  parameter int WASH_T  = 6,
  parameter int DRAIN_T = 4,
  parameter int RINSE_T = 3,
  parameter int SPIN_T  = 6,
  parameter int N_WASH  = 2,
  parameter int N_RINSE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          power,
  input  logic          start,
  input  logic          pause,
  input  logic          doorclosed,
  input  logic          soap,
  input  logic [2:0]    program_i,
  output logic          valve_cold,
  output logic          valve_hot,
  output logic          valve_out,
  output logic [1:0]    motor,
  output logic          soap_warning,
  output logic          lock_door,
  output logic          done,
  output logic [TW-1:0] remaining,
  output logic          busy
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FILL      = 4'd1,
    S_WAIT_SOAP = 4'd2,
    S_WASH      = 4'd3,
    S_DRAIN_W   = 4'd4,
    S_RINSE     = 4'd5,
    S_DRAIN_R   = 4'd6,
    S_SPIN      = 4'd7,
    S_PAUSED    = 4'd8,
    S_DONE      = 4'd9
  } state_t;

  localparam logic [TW-1:0] FILL_LD    = TW'(FILL_T - 1);
  localparam logic [TW-1:0] WASH_LD    = TW'(WASH_T - 1);
  localparam logic [TW-1:0] DRAIN_LD   = TW'(DRAIN_T - 1);
  localparam logic [TW-1:0] RINSE_LD   = TW'(RINSE_T - 1);
  localparam logic [TW-1:0] SPIN_LD    = TW'(SPIN_T - 1);
  localparam logic [TW-1:0] WASH_LAST  = TW'(N_WASH - 1);
  localparam logic [TW-1:0] RINSE_LAST = TW'(N_RINSE - 1);
  localparam logic [TW-1:0] TOT_SPIN   = TW'(SPIN_T);
  localparam logic [TW-1:0] TOT_RINSE  = TW'(N_RINSE * (RINSE_T + DRAIN_T) + SPIN_T);
  localparam logic [TW-1:0] TOT_FULL   = TW'(N_WASH * (FILL_T + WASH_T + DRAIN_T)
                                             + N_RINSE * (RINSE_T + DRAIN_T) + SPIN_T);

  state_t          state_q, state_d;
  state_t          ret_q, ret_d;
  state_t          phase_next;
  logic [2:0]      prog_q, prog_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   rem_q, rem_d;
  logic [TW-1:0]   wrnd_q, wrnd_d;
  logic [TW-1:0]   rrnd_q, rrnd_d;
  logic            prog_valid;

  function automatic logic [TW-1:0] load_of(input state_t s);
    case (s)
      S_FILL:              load_of = FILL_LD;
      S_WASH:              load_of = WASH_LD;
      S_DRAIN_W, S_DRAIN_R: load_of = DRAIN_LD;
      S_RINSE:             load_of = RINSE_LD;
      S_SPIN:              load_of = SPIN_LD;
      default:             load_of = '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      prog_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      wrnd_q  <= '0;
      rrnd_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      prog_q  <= prog_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      wrnd_q  <= wrnd_d;
      rrnd_q  <= rrnd_d;
    end
  end

  always_comb begin
    prog_valid = (program_i == 3'b000) || (program_i == 3'b001) || (program_i == 3'b100)
              || (program_i == 3'b010) || (program_i == 3'b011);
    case (state_q)
      S_FILL:    phase_next = S_WASH;
      S_WASH:    phase_next = S_DRAIN_W;
      S_DRAIN_W: phase_next = (wrnd_q == WASH_LAST) ? S_RINSE : S_FILL;
      S_RINSE:   phase_next = S_DRAIN_R;
      S_DRAIN_R: phase_next = (rrnd_q == RINSE_LAST) ? S_SPIN : S_RINSE;
      default:   phase_next = S_DONE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    prog_d  = prog_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    wrnd_d  = wrnd_q;
    rrnd_d  = rrnd_q;
    if (!power) begin
      state_d = S_IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && doorclosed && prog_valid) begin
            prog_d = program_i;
            wrnd_d = '0;
            rrnd_d = '0;
            case (program_i)
              3'b010: begin state_d = S_RINSE; cnt_d = RINSE_LD; rem_d = TOT_RINSE; end
              3'b011: begin state_d = S_SPIN;  cnt_d = SPIN_LD;  rem_d = TOT_SPIN;  end
              default: begin state_d = S_FILL; cnt_d = FILL_LD;  rem_d = TOT_FULL;  end
            endcase
          end
        end
        S_WAIT_SOAP: begin
          if (!doorclosed) begin
            state_d = S_PAUSED;
            ret_d   = S_WAIT_SOAP;
          end else if (soap) begin
            state_d = S_FILL;
          end
        end
        S_PAUSED: begin
          if (start && doorclosed) state_d = ret_q;
        end
        S_DONE: state_d = S_IDLE;
        S_FILL, S_WASH, S_DRAIN_W, S_RINSE, S_DRAIN_R, S_SPIN: begin
          // Pause outranks soap check, which outranks the phase-end advance.
          if (pause || !doorclosed) begin
            state_d = S_PAUSED;
            ret_d   = state_q;
          end else if (state_q == S_FILL && !soap) begin
            state_d = S_WAIT_SOAP;
          end else begin
            if (rem_q != '0) rem_d = rem_q - 1'b1;
            if (cnt_q == '0) begin
              state_d = phase_next;
              cnt_d   = load_of(phase_next);
              if (state_q == S_DRAIN_W && wrnd_q != WASH_LAST)  wrnd_d = wrnd_q + 1'b1;
              if (state_q == S_DRAIN_R && rrnd_q != RINSE_LAST) rrnd_d = rrnd_q + 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    valve_cold   = 1'b0;
    valve_hot    = 1'b0;
    valve_out    = 1'b0;
    motor        = 2'd0;
    soap_warning = 1'b0;
    lock_door    = 1'b0;
    done         = 1'b0;
    busy         = 1'b0;
    remaining    = '0;
    if (power) begin
      remaining = rem_q;
      busy      = (state_q != S_IDLE);
      lock_door = (state_q != S_IDLE) && (state_q != S_DONE);
      case (state_q)
        S_FILL: begin
          valve_cold = (prog_q == 3'b000) || (prog_q == 3'b100);
          valve_hot  = (prog_q == 3'b001) || (prog_q == 3'b100);
        end
        S_WASH:              motor = 2'd1;
        S_DRAIN_W, S_DRAIN_R: valve_out = 1'b1;
        S_RINSE: begin
          valve_cold = 1'b1;
          motor      = 2'd1;
        end
        S_SPIN: begin
          valve_out = 1'b1;
          motor     = 2'd2;
        end
        S_WAIT_SOAP:         soap_warning = 1'b1;
        S_DONE:              done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wash_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wash_sequencer
// Summary  : Randomised scoreboard bench for wash_sequencer against a
//            phase-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wash_sequencer;

  localparam int TW = 8, FILL_T = 4, WASH_T = 6, DRAIN_T = 4, RINSE_T = 3, SPIN_T = 6;
  localparam int N_WASH = 2, N_RINSE = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_PAUSE = 3, M_DONE = 4;
  localparam int P_FILL = 0, P_WASH = 1, P_DRW = 2, P_RINSE = 3, P_DRR = 4, P_SPIN = 5;

  logic clk = 1'b0, rst = 1'b1;
  logic power = 1'b1, start = 1'b0, pause = 1'b0, doorclosed = 1'b1, soap = 1'b1;
  logic [2:0] program_i = 3'b000;
  logic valve_cold, valve_hot, valve_out, soap_warning, lock_door, done, busy;
  logic [1:0] motor;
  logic [TW-1:0] remaining;

  wash_sequencer dut (
    .clk(clk), .rst(rst), .power(power), .start(start), .pause(pause),
    .doorclosed(doorclosed), .soap(soap), .program_i(program_i),
    .valve_cold(valve_cold), .valve_hot(valve_hot), .valve_out(valve_out),
    .motor(motor), .soap_warning(soap_warning), .lock_door(lock_door),
    .done(done), .remaining(remaining), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int push_idx = 0, mon_idx = 0, last_done = -1;
  logic [16:0] expq[$];

  // Reference model: the program is an explicit list of active cycles.
  int mmode = M_IDLE, mret = M_IDLE, midx = 0;
  int seq[$];
  logic [2:0] mprog = 3'b000;

  function automatic logic [16:0] act_vec();
    return {valve_cold, valve_hot, valve_out, motor, soap_warning, lock_door, done, busy, remaining};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s idx=%0d actual=%h required=%h", nm, mon_idx, act, exp);
  endtask

  function automatic bit valid_prog(input logic [2:0] p);
    return (p == 3'b000) || (p == 3'b001) || (p == 3'b100) || (p == 3'b010) || (p == 3'b011);
  endfunction

  function automatic void build(input logic [2:0] p);
    seq.delete();
    if (p != 3'b010 && p != 3'b011)
      for (int r = 0; r < N_WASH; r++) begin
        for (int i = 0; i < FILL_T; i++)  seq.push_back(P_FILL);
        for (int i = 0; i < WASH_T; i++)  seq.push_back(P_WASH);
        for (int i = 0; i < DRAIN_T; i++) seq.push_back(P_DRW);
      end
    if (p != 3'b011)
      for (int r = 0; r < N_RINSE; r++) begin
        for (int i = 0; i < RINSE_T; i++) seq.push_back(P_RINSE);
        for (int i = 0; i < DRAIN_T; i++) seq.push_back(P_DRR);
      end
    for (int i = 0; i < SPIN_T; i++) seq.push_back(P_SPIN);
  endfunction

  function automatic logic [16:0] exp_out(input logic pw);
    logic vc, vh, vo, sw, lk, dn, bz;
    logic [1:0] mo;
    logic [7:0] rem;
    {vc, vh, vo, sw, lk, dn, bz, mo, rem} = '0;
    if (pw) begin
      if (mmode != M_IDLE && mmode != M_DONE) begin
        lk = 1'b1; bz = 1'b1; rem = 8'(seq.size() - midx);
      end
      case (mmode)
        M_RUN: case (seq[midx])
          P_FILL: begin
            vc = (mprog == 3'b000) || (mprog == 3'b100);
            vh = (mprog == 3'b001) || (mprog == 3'b100);
          end
          P_WASH:       mo = 2'd1;
          P_DRW, P_DRR: vo = 1'b1;
          P_RINSE:      begin vc = 1'b1; mo = 2'd1; end
          default:      begin vo = 1'b1; mo = 2'd2; end
        endcase
        M_WAIT: sw = 1'b1;
        M_DONE: begin dn = 1'b1; bz = 1'b1; end
        default: ;
      endcase
    end
    return {vc, vh, vo, mo, sw, lk, dn, bz, rem};
  endfunction

  function automatic void model_step(input logic pw, st, pa, dr, so, input logic [2:0] pr);
    if (!pw) mmode = M_IDLE;
    else case (mmode)
      M_IDLE: if (st && dr && valid_prog(pr)) begin
        mprog = pr; build(pr); midx = 0; mmode = M_RUN;
      end
      M_RUN: begin
        if (pa || !dr) begin mret = M_RUN; mmode = M_PAUSE; end
        else if (seq[midx] == P_FILL && !so) mmode = M_WAIT;
        else begin
          midx++;
          if (midx == seq.size()) mmode = M_DONE;
        end
      end
      M_WAIT: begin
        if (!dr) begin mret = M_WAIT; mmode = M_PAUSE; end
        else if (so) mmode = M_RUN;
      end
      M_PAUSE: if (st && dr) mmode = mret;
      default: mmode = M_IDLE;
    endcase
  endfunction

  task automatic cyc(input logic pw, st, pa, dr, so, input logic [2:0] pr);
    power = pw; start = st; pause = pa; doorclosed = dr; soap = so; program_i = pr;
    expq.push_back(exp_out(pw));
    @(posedge clk);
    model_step(pw, st, pa, dr, so, pr);
    #1;
    push_idx++;
  endtask

  always @(negedge clk) begin
    if (!rst && expq.size() > 0) begin
      logic [16:0] e;
      e = expq.pop_front();
      check("outputs", 32'(act_vec()), 32'(e));
      if (done) last_done = mon_idx;
      mon_idx++;
    end
  end

  initial begin
    int k0;
    logic rd, rs, st;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(act_vec()), 32'h0);
    rst = 1'b0;

    // Cold wash, no disturbances: done exactly 49 cycles after the start edge.
    cyc(1, 0, 0, 1, 1, 3'b000);
    k0 = push_idx;
    cyc(1, 1, 0, 1, 1, 3'b000);
    repeat (55) cyc(1, 0, 0, 1, 1, 3'b000);
    check("cold_done_latency", 32'(last_done - k0), 32'd49);

    // Power drop during the second FILL.
    cyc(1, 1, 0, 1, 1, 3'b001);
    repeat (15) cyc(1, 0, 0, 1, 1, 3'b000);
    cyc(0, 0, 0, 1, 1, 3'b000);
    repeat (3) cyc(1, 0, 0, 1, 1, 3'b000);

    // Asynchronous reset during SPIN.
    cyc(1, 1, 0, 1, 1, 3'b011);
    repeat (3) cyc(1, 0, 0, 1, 1, 3'b011);
    check("spin_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #2;
    check("async_rst_outputs", 32'(act_vec()), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mmode = M_IDLE;

    rd = 1'b1; rs = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (rd) rd = ($urandom_range(0, 59) != 0); else rd = ($urandom_range(0, 3) == 0);
      if (rs) rs = ($urandom_range(0, 39) != 0); else rs = ($urandom_range(0, 4) == 0);
      st = (mmode == M_IDLE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 4) == 0);
      cyc($urandom_range(0, 399) != 0, st, $urandom_range(0, 29) == 0, rd, rs,
          3'($urandom_range(0, 7)));
    end
    repeat (3) cyc(1, 0, 0, 1, 1, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wash_sequencer.md
# wash_sequencer

Parametrised multi-cycle washing-machine controller, successor to the fixed-program controller. Configurable phase durations and wash/rinse repeat counts. Adds pause/resume, door-open safety pause, and an exact remaining-time countdown. Sits between the front-panel inputs and the valve/motor drivers; it replaces the three separate timer instances with one internal phase counter and one remaining-time counter.

## Interface
- TW, 8: width of the phase counter and the remaining-time counter; must hold TOTAL for every program.
- FILL_T, 4: FILL duration in cycles (≥1).
- WASH_T, 6: WASH duration in cycles (≥1).
- DRAIN_T, 4: DRAIN_W and DRAIN_R duration in cycles (≥1).
- RINSE_T, 3: RINSE duration in cycles (≥1).
- SPIN_T, 6: SPIN duration in cycles (≥1).
- N_WASH, 2: number of FILL→WASH→DRAIN_W rounds (≥1).
- N_RINSE, 2: number of RINSE→DRAIN_R rounds (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- power  in  1  low = synchronous abort to IDLE; all outputs forced 0 combinationally while low
- start  in  1  level, sampled each cycle; starts a program from IDLE, resumes from PAUSED
- pause  in  1  single-cycle pulse; requests PAUSED
- doorclosed  in  1  door sensor
- soap  in  1  detergent present
- program  in  3  000 cold, 001 hot, 100 warm, 010 rinse+spin, 011 spin only; other codes ignored
- valve_cold, valve_hot, valve_out  out  1  valve drives
- motor  out  2  0 off, 1 wash speed, 2 spin speed
- soap_warning  out  1  high in WAIT_SOAP
- lock_door  out  1  door lock
- done  out  1  one-cycle pulse in DONE
- remaining  out  TW  remaining active cycles of the program
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, FILL, WAIT_SOAP, WASH, DRAIN_W, RINSE, DRAIN_R, SPIN, PAUSED, DONE. Outputs are Moore, decoded from the registered state.
- Active phases are FILL, WASH, DRAIN_W, RINSE, DRAIN_R and SPIN.
- Program sequences:
  - 000/001/100: N_WASH × (FILL, WASH, DRAIN_W), then N_RINSE × (RINSE, DRAIN_R), then SPIN, then DONE.
  - 010: rinse rounds, then SPIN, then DONE.
  - 011: SPIN, then DONE.
- TOTAL per program:
  - 000/001/100: N_WASH·(FILL_T+WASH_T+DRAIN_T) + N_RINSE·(RINSE_T+DRAIN_T) + SPIN_T.
  - 010: N_RINSE·(RINSE_T+DRAIN_T) + SPIN_T.
  - 011: SPIN_T.
- IDLE with start & doorclosed & power & valid program:
  - program is latched into an internal register;
  - remaining ← TOTAL;
  - round counters cleared;
  - phase counter ← first phase duration − 1.
- Active phase timing:
  - the phase counter decrements each active cycle;
  - at 0 the FSM advances to the next phase and loads its duration − 1;
  - a phase lasts exactly D active cycles.
- Active cycle definition: the state is an active phase and no transition to PAUSED or WAIT_SOAP is taken that cycle. remaining decrements only on active cycles and saturates at 0. remaining = 0 on DONE entry.
- Output decode:
  - FILL: valve_cold for 000; valve_hot for 001; both for 100.
  - WASH: motor = 1.
  - DRAIN_W / DRAIN_R: valve_out.
  - RINSE: valve_cold, motor = 1.
  - SPIN: valve_out, motor = 2.
  - WAIT_SOAP / PAUSED / IDLE / DONE: valves and motor 0.
- FILL with soap = 0 → WAIT_SOAP; the phase counter and remaining are frozen. WAIT_SOAP with soap = 1 → FILL, counter resumed.
- Pause:
  - pause pulse in an active phase, or doorclosed = 0 in an active phase or WAIT_SOAP → PAUSED;
  - the return state is saved and all counters are frozen.
- PAUSED with start & doorclosed → saved state.
- lock_door: 1 in every state except IDLE and DONE. A door open in PAUSED does not unlock it.
- DONE: done = 1, then IDLE on the next cycle.
- A change on program after the start latch is ignored.

## Timing
- Reset values:
  - state IDLE;
  - all outputs 0, including lock_door, remaining and busy;
  - counters and saved state 0.
- Start latency: start sampled at edge t → FILL (or first phase) during cycle t+1, with outputs active in the same cycle. done is high during cycle t+1+TOTAL when no pauses occur.
- Pause latency: the state is PAUSED one cycle after the pause pulse or door-open sample.
- Resume latency: the saved phase is resumed one cycle after start & doorclosed.
- Simultaneous events, in priority order: power low > pause/door-open > soap missing > phase end. A pause on a phase's final cycle (counter = 0) defers the transition; after resume, one more active cycle elapses before advancing.
- pause in IDLE, DONE, PAUSED or WAIT_SOAP (with doorclosed = 1) is ignored.
- start in an active phase is ignored.
- power low mid-program → IDLE at the next edge; remaining ← 0.
- rst mid-operation → reset values immediately.

## Test plan
- Cold wash (000), default parameters, soap = 1, no pause → FILL with valve_cold for 4 cycles; done high exactly 49 cycles after the start edge; remaining steps 48→0; lock_door falls in DONE.
- Warm wash (100) with soap = 0 at start → WAIT_SOAP and soap_warning = 1 with remaining held at 48; raise soap after 10 cycles → FILL with both valves; done at 49 + 10 cycles.
- Rinse+spin (010) with a pause pulse during the 2nd WASH-free RINSE cycle → PAUSED for 5 cycles with all drives 0 and lock_door = 1; start resumes; done at 21 + 5 + 1 cycles (the pause cycle is not active).
- Spin only (011) with doorclosed dropped at cycle 3 → PAUSED; start with door still open has no effect; close the door and assert start → SPIN resumes with remaining = 3 at resume.
- Pause on the final WASH cycle (counter 0) → after resume, exactly one WASH cycle, then DRAIN_W.
- power low during the second FILL → IDLE next edge with all outputs 0; assert rst mid-SPIN → outputs 0 immediately, independent of clk.
